// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the master and the register-file slaves.
//   WB_AW / WB_DW / WB_SW : word-address, data and byte-select widths
//   REG_LED / REG_ID      : fixed register numbers in the slave register map
//   wb_slv_state_t        : slave response FSM states
package wb_pkg;

    localparam int WB_AW   = 30;
    localparam int WB_DW   = 32;
    localparam int WB_SW   = 4;

    localparam int REG_LED = 0;
    localparam int REG_ID  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wb_slv_state_t;

endpackage

// File: rtl/wb_sel_merge.sv
// Combinational byte-lane merge: lanes with sel=1 take new_data, the rest keep
// old_data.
//   old_data  in  DW     current register contents
//   new_data  in  DW     incoming write data
//   sel       in  DW/8   byte-lane enables, bit n covers [8n+7:8n]
//   merged    out DW     resulting register contents
module wb_sel_merge #(
    parameter int DW = 32,
    parameter int SW = DW / 8
) (
    input  logic [DW-1:0] old_data,
    input  logic [DW-1:0] new_data,
    input  logic [SW-1:0] sel,
    output logic [DW-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < SW; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_regfile_slave.sv
// Wishbone B4 pipelined register-file slave.
// Holds NREGS 32-bit word-addressed registers; reg0[7:0] drives o_LEDS and
// reg1 is the read-only ID_VALUE. WAIT_CYCLES inserts stalled wait states
// between accept and response; 0 gives a fully pipelined slave.
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_wb_cyc/stb/we             bus cycle, request strobe, write enable
//   i_wb_addr/data/sel          word address, write data, byte-lane enables
//   o_wb_stall                  request not accepted this cycle
//   o_wb_ack / o_wb_err         one-cycle completion pulses (mutually exclusive)
//   o_wb_data                   read data, non-zero only with a read ack
//   o_LEDS                      reg0[7:0]
module wb_regfile_slave
    import wb_pkg::*;
#(
    parameter int          NREGS       = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hB0B0_0001
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [WB_AW-1:0] i_wb_addr,
    input  logic [WB_DW-1:0] i_wb_data,
    input  logic [WB_SW-1:0] i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic             o_wb_err,
    output logic [WB_DW-1:0] o_wb_data,
    output logic [7:0]       o_LEDS
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    wb_slv_state_t    state_p1;
    logic [3:0]       cnt_p1;

    logic [WB_AW-1:0] addr_p1;
    logic             we_p1;
    logic [WB_DW-1:0] dat_p1;
    logic [WB_SW-1:0] sel_p1;

    logic             accept;
    logic             vld_p0;
    logic [WB_AW-1:0] rsp_addr;
    logic             rsp_we;
    logic [WB_DW-1:0] rsp_dat;
    logic [WB_SW-1:0] rsp_sel;
    logic             rsp_err;
    logic [IW-1:0]    rsp_idx;
    logic [WB_DW-1:0] cur_word;
    logic [WB_DW-1:0] rd_word;
    logic [WB_DW-1:0] merged;

    logic [WB_DW-1:0] regs [NREGS];

    assign o_wb_stall = (WAIT_CYCLES != 0) && (state_p1 == BUSY);
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

    // Request stage: with no wait states the response is produced straight
    // from the bus at the accept edge; otherwise from the captured request
    // when the wait counter expires (only while the cycle is still open).
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            vld_p0   = accept;
            rsp_addr = i_wb_addr;
            rsp_we   = i_wb_we;
            rsp_dat  = i_wb_data;
            rsp_sel  = i_wb_sel;
        end else begin
            vld_p0   = i_wb_cyc && (state_p1 == BUSY) && (cnt_p1 == 4'd1);
            rsp_addr = addr_p1;
            rsp_we   = we_p1;
            rsp_dat  = dat_p1;
            rsp_sel  = sel_p1;
        end
    end

    assign rsp_err  = (rsp_addr >= WB_AW'(NREGS)) ||
                      (rsp_we && (rsp_addr == WB_AW'(REG_ID)));
    assign rsp_idx  = rsp_addr[IW-1:0];
    assign cur_word = regs[rsp_idx];
    assign rd_word  = (rsp_addr == WB_AW'(REG_ID)) ? ID_VALUE : cur_word;

    wb_sel_merge #(
        .DW (WB_DW),
        .SW (WB_SW)
    ) u_sel_merge (
        .old_data (cur_word),
        .new_data (rsp_dat),
        .sel      (rsp_sel),
        .merged   (merged)
    );

    // Capture stage: request fields held for the wait-state path
    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_p1 <= i_wb_addr;
            we_p1   <= i_wb_we;
            dat_p1  <= i_wb_data;
            sel_p1  <= i_wb_sel;
        end
    end

    // Wait-state FSM; dropping cyc abandons whatever is in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
        end else if (!i_wb_cyc) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
        end else begin
            case (state_p1)
                IDLE: begin
                    if (accept && (WAIT_CYCLES != 0)) begin
                        state_p1 <= BUSY;
                        cnt_p1   <= 4'(WAIT_CYCLES);
                    end
                end
                BUSY: begin
                    if (cnt_p1 <= 4'd1) begin
                        state_p1 <= IDLE;
                        cnt_p1   <= '0;
                    end else begin
                        cnt_p1 <= cnt_p1 - 4'd1;
                    end
                end
                default: begin
                    state_p1 <= IDLE;
                    cnt_p1   <= '0;
                end
            endcase
        end
    end

    // Response stage: write commit and registered ack/err/data
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (vld_p0 && rsp_we && !rsp_err) begin
            regs[rsp_idx] <= merged;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= vld_p0 && !rsp_err;
            o_wb_err  <= vld_p0 && rsp_err;
            o_wb_data <= (vld_p0 && !rsp_err && !rsp_we) ? rd_word : '0;
        end
    end

    assign o_LEDS = regs[REG_LED][7:0];

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Bench for wb_regfile_slave: three instances (WAIT_CYCLES 0, 3, 5) share the
// clock and reset; a register-map model in the bench predicts every response.
module tb_wb_regfile_slave;

    localparam int          NREGS = 8;
    localparam logic [31:0] IDV   = 32'hB0B0_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       cyc, stb, we;
    logic [2:0][29:0] addr;
    logic [2:0][31:0] wdat;
    logic [2:0][3:0]  sel;
    logic [2:0]       stall, ack, err;
    logic [2:0][31:0] rdat;
    logic [2:0][7:0]  leds;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [3][NREGS];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_regfile_slave #(
            .NREGS       (NREGS),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 5)),
            .ID_VALUE    (IDV)
        ) u_dut (
            .i_clk      (clk),
            .i_reset_n  (rst_n),
            .i_wb_cyc   (cyc[g]),
            .i_wb_stb   (stb[g]),
            .i_wb_we    (we[g]),
            .i_wb_addr  (addr[g]),
            .i_wb_data  (wdat[g]),
            .i_wb_sel   (sel[g]),
            .o_wb_stall (stall[g]),
            .o_wb_ack   (ack[g]),
            .o_wb_err   (err[g]),
            .o_wb_data  (rdat[g]),
            .o_LEDS     (leds[g])
        );
    end

    function automatic int wv(int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < NREGS; r++)
                mdl[k][r] = '0;
    endtask

    // Applies one completed transaction to the register-map model.
    task automatic model_apply(input int k, input bit w, input int a, input logic [31:0] d,
                               input logic [3:0] s, output bit e_err, output logic [31:0] e_data);
        e_err  = (a >= NREGS) || (w && a == 1);
        e_data = '0;
        if (!e_err) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[k][a][8*b +: 8] = d[8*b +: 8];
            end else begin
                e_data = (a == 1) ? IDV : mdl[k][a];
            end
        end
    endtask

    // One complete single transaction with latency, stall and result checks.
    task automatic xfer(input int k, input bit w, input int a, input logic [31:0] d,
                        input logic [3:0] s, input string tag, output logic [31:0] obs);
        bit          e_err;
        logic [31:0] e_data;
        int          lat;
        int          guard;
        model_apply(k, w, a, d, s, e_err, e_data);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
        addr[k] = 30'(a); wdat[k] = d; sel[k] = s;
        guard = 0;
        while (stall[k] && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, "_idle_stall"}, 32'(stall[k]), 32'd0);
        tick();
        stb[k] = 1'b0;
        lat = 1;
        while (!ack[k] && !err[k] && lat < 20) begin
            chk({tag, "_busy_stall"}, 32'(stall[k]), 32'd1);
            tick();
            lat++;
        end
        obs = rdat[k];
        chk({tag, "_latency"}, 32'(lat), 32'(wv(k) + 1));
        chk({tag, "_ack"}, 32'(ack[k]), 32'(!e_err));
        chk({tag, "_err"}, 32'(err[k]), 32'(e_err));
        if (!w) chk({tag, "_rdata"}, rdat[k], e_data);
        chk({tag, "_rsp_stall"}, 32'(stall[k]), 32'd0);
        chk({tag, "_leds"}, 32'(leds[k]), 32'(mdl[k][0][7:0]));
        cyc[k] = 1'b0;
        tick();
        chk({tag, "_pulse"}, 32'({ack[k], err[k]}), 32'd0);
    endtask

    initial begin
        logic [31:0] obs;
        bit          b_err [8];
        bit          b_we  [8];
        logic [31:0] b_dat [8];
        int          prev_a;

        cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("reset_ack",   32'(ack[k]),   32'd0);
            chk("reset_err",   32'(err[k]),   32'd0);
            chk("reset_stall", 32'(stall[k]), 32'd0);
            chk("reset_data",  rdat[k],       32'd0);
            chk("reset_leds",  32'(leds[k]),  32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Basic write/read and LEDs on the pipelined instance
        xfer(0, 1'b1, 0, 32'h0000_0005, 4'hF, "w0_wr", obs);
        xfer(0, 1'b0, 0, 32'h0, 4'hF, "w0_rd", obs);
        chk("w0_rd_value", obs, 32'h5);
        chk("w0_leds", 32'(leds[0]), 32'h05);

        // Wait states and byte lanes
        xfer(1, 1'b1, 2, 32'hDEAD_BEEF, 4'hF, "w3_wr", obs);
        xfer(1, 1'b0, 2, 32'h0, 4'h0, "w3_rd", obs);
        chk("w3_rd_value", obs, 32'hDEAD_BEEF);
        xfer(1, 1'b1, 2, 32'h1122_3344, 4'b0101, "lane_wr", obs);
        xfer(1, 1'b0, 2, 32'h0, 4'hF, "lane_rd", obs);
        chk("lane_value", obs, 32'hDE22_BE44);
        xfer(1, 1'b1, 2, 32'hFFFF_FFFF, 4'h0, "sel0_wr", obs);
        xfer(1, 1'b0, 2, 32'h0, 4'hF, "sel0_rd", obs);
        chk("sel0_value", obs, 32'hDE22_BE44);

        // Error responses
        xfer(0, 1'b0, NREGS, 32'h0, 4'hF, "err_oob_rd", obs);
        chk("err_oob_data", obs, 32'h0);
        xfer(0, 1'b1, 1, 32'h1234_5678, 4'hF, "err_id_wr", obs);
        xfer(0, 1'b0, 1, 32'h0, 4'hF, "id_rd", obs);
        chk("id_value", obs, IDV);

        // Strobe without cyc is ignored
        cyc[0] = 1'b0; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = '0; wdat[0] = 32'hAA; sel[0] = 4'hF;
        tick();
        tick();
        chk("nocyc_rsp", 32'({ack[0], err[0]}), 32'd0);
        chk("nocyc_leds", 32'(leds[0]), 32'(mdl[0][0][7:0]));
        stb[0] = 1'b0;

        // Randomized single transactions on every instance
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                xfer(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS)),
                     $urandom, 4'($urandom_range(0, 15)), "rand", obs);
            end
        end

        // Back-to-back burst on the pipelined instance; odd slots read the
        // register the previous slot just targeted
        cyc[0] = 1'b1;
        prev_a = 0;
        for (int i = 0; i < 8; i++) begin
            int          a;
            bit          w;
            logic [31:0] d;
            logic [3:0]  s;
            if (i % 2 == 1) begin
                a = prev_a; w = 1'b0;
            end else begin
                a = int'($urandom_range(0, NREGS)); w = 1'($urandom_range(0, 1));
            end
            d = $urandom; s = 4'($urandom_range(0, 15));
            prev_a = a;
            b_we[i] = w;
            model_apply(0, w, a, d, s, b_err[i], b_dat[i]);
            stb[0] = 1'b1; we[0] = w; addr[0] = 30'(a); wdat[0] = d; sel[0] = s;
            chk("burst_stall", 32'(stall[0]), 32'd0);
            tick();
            chk("burst_ack", 32'(ack[0]), 32'(!b_err[i]));
            chk("burst_err", 32'(err[0]), 32'(b_err[i]));
            if (!b_we[i]) chk("burst_rdata", rdat[0], b_dat[i]);
        end
        stb[0] = 1'b0;
        tick();
        chk("burst_tail", 32'({ack[0], err[0]}), 32'd0);
        cyc[0] = 1'b0;
        tick();

        // Abort: drop cyc two cycles into a WAIT=5 write of reg0
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = '0; wdat[2] = 32'hFF; sel[2] = 4'hF;
        tick();
        stb[2] = 1'b0;
        tick();
        tick();
        cyc[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_rsp", 32'({ack[2], err[2]}), 32'd0);
        end
        chk("abort_leds", 32'(leds[2]), 32'(mdl[2][0][7:0]));
        chk("abort_stall", 32'(stall[2]), 32'd0);
        xfer(2, 1'b0, 0, 32'h0, 4'hF, "abort_rd", obs);

        // Reset in the middle of a BUSY write
        xfer(2, 1'b1, 0, 32'h0000_00C3, 4'hF, "pre_rst_wr", obs);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 30'd2; wdat[2] = 32'h1234; sel[2] = 4'hF;
        tick();
        stb[2] = 1'b0;
        tick();
        chk("busy_before_rst", 32'(stall[2]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("midrst_ack",   32'(ack[k]),   32'd0);
            chk("midrst_err",   32'(err[k]),   32'd0);
            chk("midrst_stall", 32'(stall[k]), 32'd0);
            chk("midrst_data",  rdat[k],       32'd0);
            chk("midrst_leds",  32'(leds[k]),  32'd0);
        end
        cyc = '0;
        model_reset();
        tick();
        tick();
        chk("inrst_rsp", 32'({ack[2], err[2]}), 32'd0);
        rst_n = 1'b1;
        tick();
        xfer(2, 1'b0, 2, 32'h0, 4'hF, "post_rst_rd", obs);
        xfer(2, 1'b0, 1, 32'h0, 4'hF, "post_rst_id", obs);
        xfer(0, 1'b0, 0, 32'h0, 4'hF, "post_rst_rd0", obs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
